// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - default sizing, address-width helper and typedefs for the register file
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    function automatic int rf_aw(input int nregs);
        return $clog2(nregs);
    endfunction

    localparam int RF_AW = rf_aw(RF_NREGS);

    typedef logic [RF_AW-1:0]   rf_addr_t;
    typedef logic [RF_XLEN-1:0] rf_data_t;

endpackage

// File: rtl/rf_mp_if.sv
// rtl/rf_mp_if.sv - read, write and reserve ports of the multi-port register file
interface rf_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int AW     = rf_aw(NREGS)
);
    logic [NUM_RD-1:0][AW-1:0]   rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR-1:0][AW-1:0]   wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0] wr_data;
    logic                        rsv_en;
    logic [AW-1:0]               rsv_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits: set by issue reserve, cleared by writeback
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = RF_NREGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = rf_aw(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
    input  logic                      rsv_en,
    input  logic [AW-1:0]             rsv_addr,
    input  logic [NUM_RD-1:0][AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]         rd_busy
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rsv_ok;

    assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == AW'(0));

    // Clear before set: a same-cycle reserve belongs to a newer instruction.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i]) busy_d[wr_addr[i]] = 1'b0;
        end
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    always_comb begin
        rd_busy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_busy[j] = busy_q[rd_addr[j]];
            if (BYPASS != 0 && !(ZERO_REG != 0 && rd_addr[j] == AW'(0))) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_en[i] && wr_addr[i] == rd_addr[j])
                        rd_busy[j] = rsv_ok && rsv_addr == rd_addr[j];
                end
            end
            if (!rst_n) rd_busy[j] = 1'b0;
        end
    end
endmodule

// File: rtl/rf_mp.sv
// rtl/rf_mp.sv - parametrised multi-port register file with optional bypass and zero register
module rf_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic     clk,
    input logic     rst_n,
    rf_mp_if.slave  bus
);
    localparam int AW = rf_aw(NREGS);

    logic [NREGS-1:0][XLEN-1:0]  mem_q;
    logic [NREGS-1:0][XLEN-1:0]  mem_d;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data_c;

    // Ascending port order lets the highest-index writer win a collision.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i] && !(ZERO_REG != 0 && bus.wr_addr[i] == AW'(0)))
                mem_d[bus.wr_addr[i]] = bus.wr_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    always_comb begin
        rd_data_c = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_data_c[j] = mem_q[bus.rd_addr[j]];
            if (BYPASS != 0) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.wr_en[i] && bus.wr_addr[i] == bus.rd_addr[j])
                        rd_data_c[j] = bus.wr_data[i];
                end
            end
            if (ZERO_REG != 0 && bus.rd_addr[j] == AW'(0)) rd_data_c[j] = '0;
            // Bypassed write data must not leak out while reset is held.
            if (!rst_n) rd_data_c[j] = '0;
        end
    end

    assign bus.rd_data = rd_data_c;

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (bus.rd_busy)
    );
endmodule

// File: tb/tb_rf_mp.sv
// tb/tb_rf_mp.sv - directed scoreboard bench for rf_mp, no-bypass and bypass instances
module tb_rf_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_mp_if #(.NUM_WR(2)) ifa ();
    rf_mp_if #(.NUM_WR(2)) ifb ();

    rf_mp #(.NUM_WR(2), .BYPASS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rf_mp #(.NUM_WR(2), .BYPASS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifb.rd_addr  = ifa.rd_addr;
    assign ifb.wr_en    = ifa.wr_en;
    assign ifb.wr_addr  = ifa.wr_addr;
    assign ifb.wr_data  = ifa.wr_data;
    assign ifb.rsv_en   = ifa.rsv_en;
    assign ifb.rsv_addr = ifa.rsv_addr;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input logic [31:0] obs);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        ifa.wr_en    = '0;
        ifa.wr_addr  = '0;
        ifa.wr_data  = '0;
        ifa.rsv_en   = 1'b0;
        ifa.rsv_addr = '0;
    endtask

    initial begin
        idle();
        ifa.rd_addr = '0;
        #1;
        expect_val("reset_data0", 32'h0);   check_val(ifa.rd_data[0]);
        expect_val("reset_busy0", 32'h0);   check_val({31'b0, ifa.rd_busy[0]});

        @(negedge clk); rst_n = 1'b1;

        // Reset wipes stored data without a clock edge
        @(negedge clk);
        ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd5; ifa.wr_data[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        idle(); ifa.rd_addr[0] = 5'd5;
        #1;
        expect_val("x5_written", 32'hDEAD_BEEF); check_val(ifa.rd_data[0]);
        ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd5; ifa.wr_data[0] = 32'h1234_5678;
        #1; rst_n = 1'b0; #1;
        expect_val("rst_x5_data_nb", 32'h0); check_val(ifa.rd_data[0]);
        expect_val("rst_x5_data_bp", 32'h0); check_val(ifb.rd_data[0]);
        expect_val("rst_x5_busy_bp", 32'h0); check_val({31'b0, ifb.rd_busy[0]});
        idle();
        @(negedge clk); rst_n = 1'b1;

        // Basic write/read
        @(negedge clk);
        ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd4; ifa.wr_data[0] = 32'd42;
        ifa.rd_addr[0] = 5'd4; ifa.rd_addr[1] = 5'd2;
        #1;
        expect_val("x4_same_cycle_nb", 32'd0);  check_val(ifa.rd_data[0]);
        expect_val("x4_same_cycle_bp", 32'd42); check_val(ifb.rd_data[0]);
        @(negedge clk);
        idle(); ifa.rd_addr[0] = 5'd4; ifa.rd_addr[1] = 5'd0;
        #1;
        expect_val("x4_next_nb", 32'd42); check_val(ifa.rd_data[0]);
        expect_val("x0_read_nb", 32'd0);  check_val(ifa.rd_data[1]);

        // Bypass
        @(negedge clk);
        ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd2; ifa.wr_data[0] = 32'd99;
        ifa.rd_addr[0] = 5'd2; ifa.rd_addr[1] = 5'd4;
        #1;
        expect_val("bypass_x2", 32'd99);  check_val(ifb.rd_data[0]);
        expect_val("bypass_x4", 32'd42);  check_val(ifb.rd_data[1]);
        expect_val("nobypass_x2", 32'd0); check_val(ifa.rd_data[0]);

        // Write collision
        @(negedge clk);
        ifa.wr_en = 2'b11;
        ifa.wr_addr[0] = 5'd7; ifa.wr_data[0] = 32'd1;
        ifa.wr_addr[1] = 5'd7; ifa.wr_data[1] = 32'd2;
        ifa.rd_addr[0] = 5'd7;
        #1;
        expect_val("collide_bp", 32'd2); check_val(ifb.rd_data[0]);
        @(negedge clk);
        idle();
        #1;
        expect_val("collide_nb", 32'd2); check_val(ifa.rd_data[0]);

        // Scoreboard
        @(negedge clk);
        ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd3; ifa.rd_addr[0] = 5'd3; ifa.rd_addr[1] = 5'd3;
        #1;
        expect_val("rsv_same_cycle_nb", 32'd0); check_val({31'b0, ifa.rd_busy[0]});
        expect_val("rsv_same_cycle_bp", 32'd0); check_val({31'b0, ifb.rd_busy[0]});
        @(negedge clk);
        idle();
        #1;
        expect_val("x3_busy_nb", 32'd1); check_val({31'b0, ifa.rd_busy[0]});
        expect_val("x3_busy_bp", 32'd1); check_val({31'b0, ifb.rd_busy[1]});
        @(negedge clk);
        ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd3; ifa.wr_data[0] = 32'd11;
        ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd3;
        #1;
        expect_val("wr_rsv_busy_bp", 32'd1); check_val({31'b0, ifb.rd_busy[0]});
        expect_val("wr_rsv_data_bp", 32'd11); check_val(ifb.rd_data[0]);
        @(negedge clk);
        idle();
        #1;
        expect_val("wr_rsv_busy_nb", 32'd1);  check_val({31'b0, ifa.rd_busy[0]});
        expect_val("wr_rsv_data_nb", 32'd11); check_val(ifa.rd_data[0]);
        @(negedge clk);
        ifa.wr_en[1] = 1'b1; ifa.wr_addr[1] = 5'd3; ifa.wr_data[1] = 32'd12;
        #1;
        expect_val("wb_busy_bp", 32'd0);  check_val({31'b0, ifb.rd_busy[0]});
        expect_val("wb_data_bp", 32'd12); check_val(ifb.rd_data[1]);
        expect_val("wb_busy_pre_nb", 32'd1); check_val({31'b0, ifa.rd_busy[1]});
        @(negedge clk);
        idle();
        #1;
        expect_val("wb_busy_nb", 32'd0);  check_val({31'b0, ifa.rd_busy[0]});
        expect_val("wb_data_nb", 32'd12); check_val(ifa.rd_data[0]);

        // Zero register
        @(negedge clk);
        ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd0;
        ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd0; ifa.wr_data[0] = 32'hFFFF_FFFF;
        ifa.rd_addr[0] = 5'd0;
        #1;
        expect_val("x0_data_bp", 32'd0); check_val(ifb.rd_data[0]);
        expect_val("x0_busy_bp", 32'd0); check_val({31'b0, ifb.rd_busy[0]});
        @(negedge clk);
        idle();
        #1;
        expect_val("x0_data_nb", 32'd0); check_val(ifa.rd_data[0]);
        expect_val("x0_busy_nb", 32'd0); check_val({31'b0, ifa.rd_busy[0]});
        expect_val("x0_data_bp2", 32'd0); check_val(ifb.rd_data[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_mp.md
# rf_mp

Parametrised multi-port integer register file with a built-in busy scoreboard. It replaces the fixed two-read/one-write `rf` in the core datapath. Its sizing also fits wider-issue configurations:

- configurable data width, register count, read-port count and write-port count;
- optional same-cycle write-to-read bypass;
- hardwired zero register;
- per-register busy bit that the issue stage sets and writeback clears.

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of architectural registers; power of two, ≥ 2.
- `NUM_RD`, 2, read ports.
- `NUM_WR`, 1, write ports.
- `ZERO_REG`, 1, register 0 reads 0 and ignores writes when 1.
- `BYPASS`, 1, same-cycle write data forwarded to reads when 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  NUM_RD×AW  read addresses; AW = $clog2(NREGS).
- `rd_data`  out  NUM_RD×XLEN  read data.
- `rd_busy`  out  NUM_RD  busy bit of each addressed register.
- `wr_en`  in  NUM_WR  write enables.
- `wr_addr`  in  NUM_WR×AW  write addresses.
- `wr_data`  in  NUM_WR×XLEN  write data.
- `rsv_en`  in  1  reserve request from issue; sets the busy bit.
- `rsv_addr`  in  AW  register to reserve.

## Operation
- Storage is NREGS×XLEN flops plus an NREGS-bit busy vector.
- **Reset:**
  - `rst_n` low asynchronously clears every register and every busy bit.
  - While reset is held, `rd_data` = 0 and `rd_busy` = 0 for all ports.
  - Writes or reservations in flight when reset asserts are lost.
- **Write:** when `wr_en[i]` is set, `wr_data[i]` is stored to `wr_addr[i]` at the rising edge. The same edge clears the busy bit of `wr_addr[i]`.
- **Write collision:** if several write ports target the same address in one cycle, the highest port index wins. The busy bit is cleared once.
- **Reserve:** `rsv_en` sets the busy bit of `rsv_addr` at the rising edge.
  - Reserving and writing back the same register in the same cycle leaves busy = 1. The reservation belongs to a newer instruction.
  - Reserving an already-busy register leaves it busy; this is not an error.
- **Zero register** (`ZERO_REG`=1):
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
  - Reservations of address 0 are discarded, so `rd_busy` is always 0 for address 0.
- **Bypass** (`BYPASS`=1):
  - If any enabled write port targets `rd_addr[j]` in the current cycle, `rd_data[j]` returns that port's `wr_data`, using the highest-index port on collision.
  - `rd_busy[j]` returns 0 in that case, unless `rsv_en` targets the same address in that cycle.
  - Address 0 is never bypassed when `ZERO_REG`=1.
- **No bypass** (`BYPASS`=0): reads return the pre-edge stored value and busy bit.
- Out-of-range addresses cannot occur because NREGS is a power of two.

## Timing
- Reads are combinational from `rd_addr`, state and, with bypass on, the write and reserve inputs. Read latency is 0 cycles.
- Write-to-read latency:
  - 1 cycle with `BYPASS`=0; the value is visible after the edge.
  - 0 cycles with `BYPASS`=1.
- Reserve-to-busy latency: 1 cycle. Busy is visible after the edge; there is no bypass of reservation into `rd_busy` except in the same-cycle reserve-and-write case described above.
- The only sequential paths are the register array and busy vector. No output is registered.

## Structure
- Package `rf_pkg` holds:
  - default constants for `XLEN` and `NREGS`;
  - the function computing AW;
  - typedefs `rf_addr_t` and `rf_data_t` for the default 32×32 configuration.
- Sub-module `rf_scoreboard` holds the busy vector, set/clear logic and `rd_busy` lookup. Its ports are `clk`, `rst_n`, write clears, reserve set and read addresses.
- The top level holds the data array, write-collision priority and bypass mux.

## Test plan
- **Reset:** write x5 = 0xDEAD_BEEF, then pulse `rst_n` low mid-cycle. Reading x5 returns 0 with busy 0, with no clock edge needed.
- **Basic write/read** (`BYPASS`=0): write x4 = 42. Same cycle, `rd_data[0]` for x4 = 0. Next cycle, x4 = 42 and x0 = 0.
- **Bypass** (`BYPASS`=1): write x2 = 99 while reading x2 and x4 in the same cycle. Returns 99 and 42.
- **Collision** (`NUM_WR`=2): port0 writes x7 = 1 and port1 writes x7 = 2 in the same cycle. x7 reads 2 next cycle.
- **Scoreboard:**
  - Reserve x3, then read x3: busy 1.
  - Write x3 = 11 together with a reserve of x3: busy stays 1, data = 11.
  - Write x3 = 12 without a reserve: busy 0.
- **Zero register:** reserve x0 and write x0 = 0xFFFF_FFFF. x0 reads 0 with busy 0.
